// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types, encodings and the RAW-match helper for the pipeline hazard logic
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] WDSEL_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // x0 is hardwired to zero, so it never creates a dependency
    function automatic logic raw_hit(
        input logic       re,
        input logic [4:0] rs,
        input logic [4:0] rd,
        input logic       we
    );
        return re && (rs != 5'd0) && (rs == rd) && we;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: per-operand RAW match against EX/MEM/WB and youngest-first forward select (HAZARD_FORWARD_EN)
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       re,
    input  logic [4:0] ex_rd,
    input  logic       ex_rfwe,
    input  logic       ex_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_rfwe,
    input  logic [4:0] wb_rd,
    input  logic       wb_rfwe,
    output logic [2:0] hit,
    output logic [1:0] fwd
);

    // hit bits are {EX, MEM, WB}
    always_comb begin
        hit = {raw_hit(re, rs, ex_rd, ex_rfwe),
               raw_hit(re, rs, mem_rd, mem_rfwe),
               raw_hit(re, rs, wb_rd, wb_rfwe)};
    end

`ifdef HAZARD_FORWARD_EN
    // a load in EX has no data yet: select nothing rather than a stale older stage
    always_comb begin
        fwd = hit[2] ? (ex_load ? FWD_RF : FWD_EX) :
              hit[1] ? FWD_MEM :
              hit[0] ? FWD_WB  : FWD_RF;
    end
`else
    logic unused_load;
    assign unused_load = ex_load;
    assign fwd         = FWD_RF;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control, DM wait FSM, watchdog and perf counters (HAZARD_FORWARD_EN enables forwarding)
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_rfwe,
    input  logic             mem_rfwe,
    input  logic             wb_rfwe,
    input  logic [1:0]       ex_wdsel,
    input  logic             ex_br_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]       hit_a, hit_b;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             ex_load, mem_wait, data_haz, br_flush;

    assign ex_load = (ex_wdsel == WDSEL_LOAD);

    fwd_sel u_fwd_a (
        .rs(id_rs1), .re(id_re1),
        .ex_rd(ex_rd), .ex_rfwe(ex_rfwe), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_rfwe(mem_rfwe),
        .wb_rd(wb_rd), .wb_rfwe(wb_rfwe),
        .hit(hit_a), .fwd(fwd_a_sel)
    );

    fwd_sel u_fwd_b (
        .rs(id_rs2), .re(id_re2),
        .ex_rd(ex_rd), .ex_rfwe(ex_rfwe), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_rfwe(mem_rfwe),
        .wb_rd(wb_rd), .wb_rfwe(wb_rfwe),
        .hit(hit_b), .fwd(fwd_b_sel)
    );

`ifdef HAZARD_FORWARD_EN
    assign data_haz = ex_load && (hit_a[2] || hit_b[2]);
`else
    assign data_haz = |{hit_a, hit_b};
`endif

    // Mealy decode: reset > memory wait > branch > data hazard
    always_comb begin
        mem_wait    = (state_q == RUN) ? (dm_req && !dm_ready) : !dm_ready;
        br_flush    = !rst && !mem_wait && ex_br_taken;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (data_haz) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
        fwd_a = rst ? FWD_RF : fwd_a_sel;
        fwd_b = rst ? FWD_RF : fwd_b_sel;
    end

    // next state, saturating wait watchdog with sticky error, wrapping perf counters
    always_comb begin
        state_d     = (state_q == RUN) ? ((dm_req && !dm_ready) ? MEM_WAIT : RUN)
                                       : (dm_ready ? RUN : MEM_WAIT);
        wd_cnt_d    = !mem_wait ? '0 :
                      (wd_cnt_q == WD_W'(MEM_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + 1'b1;
        err_d       = err_q || (wd_cnt_d == WD_W'(MEM_TIMEOUT));
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(br_flush);
    end

    // state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err_timeout = err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard control, memory wait, watchdog and counters (expectations follow HAZARD_FORWARD_EN)
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_re1, id_re2, ex_rfwe, mem_rfwe, wb_rfwe;
    logic [1:0]  ex_wdsel;
    logic        ex_br_taken, dm_req, dm_ready;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        err_timeout;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  ctl;
    int          n_cmp, n_err;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_rfwe(ex_rfwe), .mem_rfwe(mem_rfwe), .wb_rfwe(wb_rfwe),
        .ex_wdsel(ex_wdsel), .ex_br_taken(ex_br_taken),
        .dm_req(dm_req), .dm_ready(dm_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .err_timeout(err_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_rfwe = 0; mem_rfwe = 0; wb_rfwe = 0;
        ex_wdsel = 0; ex_br_taken = 0; dm_req = 0; dm_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        clear_in();
        step();
        #2;
        check("rst_ctl", 32'(ctl), 32'h0F);
        check("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        check("rst_err", 32'(err_timeout), 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_flush_cnt", flush_cnt, 32'h0);
        rst = 1'b0;
        step();
        #2;
        check("idle_ctl", 32'(ctl), 32'h0);

        id_rs1 = 5; id_re1 = 1; ex_rd = 5; ex_rfwe = 1; ex_wdsel = 2'b01;
        #2;
        check("lu_c0_ctl", 32'(ctl), 32'hC4);
        check("lu_c0_fwd", 32'(fwd_a), 32'h0);
        step();
        ex_rd = 0; ex_rfwe = 0; ex_wdsel = 0; mem_rd = 5; mem_rfwe = 1;
        #2;
        check("lu_c1_ctl", 32'(ctl), FWD ? 32'h0 : 32'hC4);
        check("lu_c1_fwd", 32'(fwd_a), FWD ? 32'h2 : 32'h0);
        step();
        mem_rd = 0; mem_rfwe = 0; wb_rd = 5; wb_rfwe = 1;
        #2;
        check("lu_c2_ctl", 32'(ctl), FWD ? 32'h0 : 32'hC4);
        check("lu_c2_fwd", 32'(fwd_a), FWD ? 32'h3 : 32'h0);
        step();
        wb_rd = 0; wb_rfwe = 0;
        #2;
        check("lu_c3_ctl", 32'(ctl), 32'h0);
        check("lu_stall_cnt", stall_cnt, FWD ? 32'd1 : 32'd3);

        do_reset();
        id_rs1 = 5; id_re1 = 1; ex_rd = 5; ex_rfwe = 1; mem_rd = 5; mem_rfwe = 1;
        id_rs2 = 7; id_re2 = 1; wb_rd = 7; wb_rfwe = 1;
        #2;
        check("prio_ctl", 32'(ctl), FWD ? 32'h0 : 32'hC4);
        check("prio_fwd_a_ex", 32'(fwd_a), FWD ? 32'h1 : 32'h0);
        check("prio_fwd_b_wb", 32'(fwd_b), FWD ? 32'h3 : 32'h0);
        mem_rd = 7;
        #2;
        check("prio_fwd_b_mem", 32'(fwd_b), FWD ? 32'h2 : 32'h0);

        do_reset();
        id_rs1 = 0; id_re1 = 1; ex_rd = 0; ex_rfwe = 1; ex_wdsel = 2'b01;
        #2;
        check("x0_ctl", 32'(ctl), 32'h0);
        check("x0_fwd", 32'(fwd_a), 32'h0);
        id_rs1 = 5; id_re1 = 0; ex_rd = 5;
        #2;
        check("nore_ctl", 32'(ctl), 32'h0);

        do_reset();
        id_rs1 = 5; id_re1 = 1; ex_rd = 5; ex_rfwe = 1; ex_wdsel = 2'b01; ex_br_taken = 1;
        #2;
        check("br_ctl", 32'(ctl), 32'h0C);
        check("br_flush_cnt0", flush_cnt, 32'h0);
        step();
        clear_in();
        #2;
        check("br_flush_cnt1", flush_cnt, 32'h1);
        check("br_stall_cnt", stall_cnt, 32'h0);

        do_reset();
        dm_req = 1; ex_br_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("mw_ctl", 32'(ctl), 32'hF1);
            step();
        end
        dm_ready = 1;
        #2;
        check("mw_release_ctl", 32'(ctl), 32'h0C);
        step();
        clear_in();
        #2;
        check("mw_run_ctl", 32'(ctl), 32'h0);
        check("mw_stall_cnt", stall_cnt, 32'd4);
        check("mw_flush_cnt", flush_cnt, 32'd1);

        do_reset();
        dm_req = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            #2;
            check("to_err", 32'(err_timeout), 32'(i >= 3));
        end
        dm_ready = 1; dm_req = 0;
        step();
        #2;
        check("to_sticky", 32'(err_timeout), 32'h1);
        check("to_ctl_after", 32'(ctl), 32'h0);
        dm_req = 1; dm_ready = 0;
        step();
        rst = 1;
        #2;
        check("rstmw_ctl", 32'(ctl), 32'h0F);
        step();
        rst = 0; dm_req = 0;
        #2;
        check("rstmw_run_ctl", 32'(ctl), 32'h0);
        check("rstmw_err", 32'(err_timeout), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
